// File: rtl/dp_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// dp_transfer_sequencer
//
// Purpose:
//   Expands a 3-bit macro command into one or two timed register transfers on
//   the 8-bit datapath. Each transfer first drives the source/destination
//   selects with srcen for SETUP_CYCLES cycles. It then raises dsten for
//   HOLD_CYCLES cycles. A one-cycle done pulse closes the command.
//
// Handshake:
//   start is sampled only while the sequencer is idle. The edge that samples
//   start=1 accepts the command and latches cmd. busy is high from the next
//   cycle through the done cycle. While busy, start and cmd are ignored.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset, has priority over everything
//   i_start    command request
//   i_cmd      macro command (0 NOP .. 7 ECHO)
//   o_busy     command in progress
//   o_done     one-cycle completion pulse
//   o_seldst   destination select (1=ACC, 2=BREG, 4=PortOUT, 0=none)
//   o_selsrc   source select (1=ACC, 2=BREG, 3=PortIN, 0=none)
//   o_srcen    source enable
//   o_dsten    destination enable
//   o_state    current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module dp_transfer_sequencer #(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 2,
    parameter int CNT_W        = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [2:0] i_cmd,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_seldst,
    output logic [2:0] o_selsrc,
    output logic       o_srcen,
    output logic       o_dsten,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_cmd;
    logic             r_step;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_seldst;
    logic [2:0]       r_selsrc;
    logic             r_srcen;
    logic             r_dsten;

    // {seldst, selsrc} for a command and transfer step. Only ECHO has a
    // second step, which forwards the accumulator to the output port.
    function automatic logic [5:0] route(input logic [2:0] cmd, input logic step);
        logic [5:0] codes;
        codes = 6'd0;
        case (cmd)
            3'd1: codes = {3'd1, 3'd3};
            3'd2: codes = {3'd2, 3'd3};
            3'd3: codes = {3'd4, 3'd1};
            3'd4: codes = {3'd4, 3'd2};
            3'd5: codes = {3'd2, 3'd1};
            3'd6: codes = {3'd1, 3'd2};
            3'd7: codes = step ? {3'd4, 3'd1} : {3'd1, 3'd3};
            default: codes = 6'd0;
        endcase
        return codes;
    endfunction

    // Outputs are computed with the next state, so each one is a register
    // that reflects the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cmd    <= 3'd0;
            r_step   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_seldst <= 3'd0;
            r_selsrc <= 3'd0;
            r_srcen  <= 1'b0;
            r_dsten  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cmd  <= i_cmd;
                        r_step <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_cmd == 3'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state               <= ST_SETUP;
                            {r_seldst, r_selsrc}  <= route(i_cmd, 1'b0);
                            r_srcen               <= 1'b1;
                            r_cnt                 <= SETUP_LOAD;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_XFER;
                        r_dsten <= 1'b1;
                        r_cnt   <= HOLD_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (r_cnt == '0) begin
                        // dsten drops on the same edge the selects move,
                        // so the destination never sees a select change.
                        r_dsten <= 1'b0;
                        if (r_cmd == 3'd7 && !r_step) begin
                            r_step               <= 1'b1;
                            r_state              <= ST_SETUP;
                            {r_seldst, r_selsrc} <= route(r_cmd, 1'b1);
                            r_cnt                <= SETUP_LOAD;
                        end else begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_seldst <= 3'd0;
                            r_selsrc <= 3'd0;
                            r_srcen  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_seldst <= 3'd0;
                    r_selsrc <= 3'd0;
                    r_srcen  <= 1'b0;
                    r_dsten  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_seldst = r_seldst;
    assign o_selsrc = r_selsrc;
    assign o_srcen  = r_srcen;
    assign o_dsten  = r_dsten;
    assign o_state  = r_state;

endmodule

// File: tb/tb_dp_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dp_transfer_sequencer
//
// Two sequencer instances share the clock. Instance A uses S=1, H=2 and
// instance B uses S=3, H=4. Each has its own inputs. A reference model turns
// every accepted command into the full expected output trace, held in an
// expected queue. The trace is derived from the command table and the S/H
// timing. Output vectors are packed as
// {busy, done, seldst[2:0], selsrc[2:0], srcen, dsten}.
// ---------------------------------------------------------------------------
module tb_dp_transfer_sequencer;

    localparam int S_A = 1;
    localparam int H_A = 2;
    localparam int S_B = 3;
    localparam int H_B = 4;

    logic       clk;
    logic       rst_a, start_a, rst_b, start_b;
    logic [2:0] cmd_a, cmd_b;
    logic       busy_a, done_a, srcen_a, dsten_a;
    logic       busy_b, done_b, srcen_b, dsten_b;
    logic [2:0] seldst_a, selsrc_a, seldst_b, selsrc_b;
    logic [1:0] state_a, state_b;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dp_transfer_sequencer #(.SETUP_CYCLES(S_A), .HOLD_CYCLES(H_A), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_cmd(cmd_a),
        .o_busy(busy_a), .o_done(done_a), .o_seldst(seldst_a), .o_selsrc(selsrc_a),
        .o_srcen(srcen_a), .o_dsten(dsten_a), .o_state(state_a)
    );

    dp_transfer_sequencer #(.SETUP_CYCLES(S_B), .HOLD_CYCLES(H_B), .CNT_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_cmd(cmd_b),
        .o_busy(busy_b), .o_done(done_b), .o_seldst(seldst_b), .o_selsrc(selsrc_b),
        .o_srcen(srcen_b), .o_dsten(dsten_b), .o_state(state_b)
    );

    wire [9:0] obs_a = {busy_a, done_a, seldst_a, selsrc_a, srcen_a, dsten_a};
    wire [9:0] obs_b = {busy_b, done_b, seldst_b, selsrc_b, srcen_b, dsten_b};

    // ---------------- reference model ----------------
    function automatic int n_xfers(input logic [2:0] c);
        if (c == 3'd0) return 0;
        if (c == 3'd7) return 2;
        return 1;
    endfunction

    function automatic int trace_len(input logic [2:0] c, input int s, input int h);
        return n_xfers(c) * (s + h) + 1;
    endfunction

    // Expected outputs i cycles after the first busy cycle of command c.
    function automatic logic [9:0] trace_vec(input logic [2:0] c, input int s,
                                             input int h, input int i);
        int per, t, ph;
        logic [2:0] dst, src;
        per = s + h;
        if (i >= n_xfers(c) * per) return {1'b1, 1'b1, 8'd0};
        t  = i / per;
        ph = i % per;
        dst = 3'd0;
        src = 3'd0;
        case (c)
            3'd1: begin src = 3'd3; dst = 3'd1; end
            3'd2: begin src = 3'd3; dst = 3'd2; end
            3'd3: begin src = 3'd1; dst = 3'd4; end
            3'd4: begin src = 3'd2; dst = 3'd4; end
            3'd5: begin src = 3'd1; dst = 3'd2; end
            3'd6: begin src = 3'd2; dst = 3'd1; end
            default: begin
                if (t == 0) begin src = 3'd3; dst = 3'd1; end
                else        begin src = 3'd1; dst = 3'd4; end
            end
        endcase
        return {1'b1, 1'b0, dst, src, 1'b1, (ph >= s)};
    endfunction

    logic [9:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];
    logic [9:0] cur_a = 10'd0;
    logic [9:0] cur_b = 10'd0;

    // A command is accepted only at the edge that closes an idle cycle,
    // meaning the queue is empty and the current cycle is not busy.
    always @(posedge clk) begin
        if (rst_a) begin
            exp_q_a.delete();
            cur_a = 10'd0;
        end else if (exp_q_a.size() > 0) begin
            cur_a = exp_q_a.pop_front();
        end else if (!cur_a[9] && start_a) begin
            for (int i = 0; i < trace_len(cmd_a, S_A, H_A); i++)
                exp_q_a.push_back(trace_vec(cmd_a, S_A, H_A, i));
            cur_a = exp_q_a.pop_front();
        end else begin
            cur_a = 10'd0;
        end
    end

    always @(posedge clk) begin
        if (rst_b) begin
            exp_q_b.delete();
            cur_b = 10'd0;
        end else if (exp_q_b.size() > 0) begin
            cur_b = exp_q_b.pop_front();
        end else if (!cur_b[9] && start_b) begin
            for (int i = 0; i < trace_len(cmd_b, S_B, H_B); i++)
                exp_q_b.push_back(trace_vec(cmd_b, S_B, H_B, i));
            cur_b = exp_q_b.pop_front();
        end else begin
            cur_b = 10'd0;
        end
    end

    // ---------------- driver ----------------
    // Inputs change at the falling edge. Outputs are sampled there too.
    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_a = 1'b1; start_a = 1'b1; cmd_a = 3'd1;
        rst_b = 1'b1; start_b = 1'b1; cmd_b = 3'd1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                rst_a = 1'b0; start_a = 1'b0;
                rst_b = 1'b0; start_b = 1'b0;
            end
            next_cycle();
            checks++;
            if (obs_a !== 10'd0) begin
                errors++;
                $display("FAIL reset_a cyc=%0d got=%h exp=000", c, obs_a);
            end
            checks++;
            if (obs_b !== 10'd0) begin
                errors++;
                $display("FAIL reset_b cyc=%0d got=%h exp=000", c, obs_b);
            end
        end
    endtask

    task automatic test_in_acc;
        logic [9:0] exp_t[5];
        exp_t = '{{1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b0},
                  {1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1},
                  {1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1},
                  {1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0},
                  10'd0};
        cmd_a = 3'd1; start_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a !== exp_t[c-1]) begin
                errors++;
                $display("FAIL in_acc cyc=%0d got=%h exp=%h", c, obs_a, exp_t[c-1]);
            end
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL in_acc_model cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
        end
    endtask

    task automatic test_echo;
        logic [9:0] exp_t[8];
        exp_t = '{{1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b0},
                  {1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1},
                  {1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1},
                  {1'b1, 1'b0, 3'd4, 3'd1, 1'b1, 1'b0},
                  {1'b1, 1'b0, 3'd4, 3'd1, 1'b1, 1'b1},
                  {1'b1, 1'b0, 3'd4, 3'd1, 1'b1, 1'b1},
                  {1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0},
                  10'd0};
        cmd_a = 3'd7; start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a !== exp_t[c-1]) begin
                errors++;
                $display("FAIL echo cyc=%0d got=%h exp=%h", c, obs_a, exp_t[c-1]);
            end
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL echo_model cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
        end
    endtask

    // OUT_BREG with start toggled at cmd=5 while busy. start stays high
    // through done, so MOV_AB is accepted at the idle edge after it.
    task automatic test_handshake;
        cmd_a = 3'd4; start_a = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL handshake_model cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
            if (c <= 3) begin
                checks++;
                if (obs_a[7:2] !== {3'd4, 3'd2}) begin
                    errors++;
                    $display("FAIL handshake_sel cyc=%0d got=%h exp=%h", c, obs_a[7:2], {3'd4, 3'd2});
                end
            end
            if (c == 4) begin
                checks++;
                if (obs_a !== {1'b1, 1'b1, 8'd0}) begin
                    errors++;
                    $display("FAIL handshake_done got=%h exp=%h", obs_a, {1'b1, 1'b1, 8'd0});
                end
            end
            if (c == 5) begin
                checks++;
                if (obs_a !== 10'd0) begin
                    errors++;
                    $display("FAIL handshake_idle got=%h exp=000", obs_a);
                end
            end
            if (c == 6) begin
                checks++;
                if (obs_a !== {1'b1, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL handshake_mov got=%h exp=%h", obs_a, {1'b1, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0});
                end
            end
            if (c == 9) begin
                checks++;
                if (obs_a[8] !== 1'b1) begin
                    errors++;
                    $display("FAIL handshake_mov_done got=%b exp=1", obs_a[8]);
                end
            end
            case (c)
                1: begin start_a = 1'b0; cmd_a = 3'd5; end
                2: start_a = 1'b1;
                3: start_a = 1'b0;
                4: start_a = 1'b1;
                5: start_a = 1'b1;
                default: start_a = 1'b0;
            endcase
        end
    endtask

    task automatic test_abort;
        cmd_a = 3'd2; start_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start_a = 1'b0;
            rst_a   = (c == 2);
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL abort_model cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
            if (c == 2) begin
                checks++;
                if (obs_a !== {1'b1, 1'b0, 3'd2, 3'd3, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL abort_xfer got=%h exp=%h", obs_a, {1'b1, 1'b0, 3'd2, 3'd3, 1'b1, 1'b1});
                end
            end
            if (c >= 3) begin
                checks++;
                if (obs_a !== 10'd0) begin
                    errors++;
                    $display("FAIL abort_quiet cyc=%0d got=%h exp=000", c, obs_a);
                end
            end
        end
        cmd_a = 3'd3; start_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL after_abort_model cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
            if (c == S_A + H_A + 1) begin
                checks++;
                if (obs_a !== {1'b1, 1'b1, 8'd0}) begin
                    errors++;
                    $display("FAIL after_abort_done got=%h exp=%h", obs_a, {1'b1, 1'b1, 8'd0});
                end
            end
        end
    endtask

    task automatic test_nop;
        cmd_a = 3'd0; start_a = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            start_a = 1'b0;
            checks++;
            if (obs_a !== ((c == 1) ? {1'b1, 1'b1, 8'd0} : 10'd0)) begin
                errors++;
                $display("FAIL nop cyc=%0d got=%h", c, obs_a);
            end
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL nop_model cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
        end
    endtask

    task automatic test_sweep;
        logic [9:0] exp_v;
        cmd_b = 3'd1; start_b = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            start_b = 1'b0;
            if (c <= 3)      exp_v = {1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b0};
            else if (c <= 7) exp_v = {1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1};
            else if (c == 8) exp_v = {1'b1, 1'b1, 8'd0};
            else             exp_v = 10'd0;
            checks++;
            if (obs_b !== exp_v) begin
                errors++;
                $display("FAIL sweep cyc=%0d got=%h exp=%h", c, obs_b, exp_v);
            end
            checks++;
            if (obs_b !== cur_b) begin
                errors++;
                $display("FAIL sweep_model cyc=%0d got=%h exp=%h", c, obs_b, cur_b);
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 600; c++) begin
            rst_a   = ($urandom_range(0, 39) == 0);
            start_a = ($urandom_range(0, 2) != 0);
            cmd_a   = 3'($urandom_range(0, 7));
            rst_b   = ($urandom_range(0, 59) == 0);
            start_b = ($urandom_range(0, 2) != 0);
            cmd_b   = 3'($urandom_range(0, 7));
            next_cycle();
            checks++;
            if (obs_a !== cur_a) begin
                errors++;
                $display("FAIL random_a cyc=%0d got=%h exp=%h", c, obs_a, cur_a);
            end
            checks++;
            if (obs_b !== cur_b) begin
                errors++;
                $display("FAIL random_b cyc=%0d got=%h exp=%h", c, obs_b, cur_b);
            end
        end
        rst_a = 1'b0; start_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_a = 1'b1; start_a = 1'b0; cmd_a = 3'd0;
        rst_b = 1'b1; start_b = 1'b0; cmd_b = 3'd0;
        @(negedge clk);
        test_reset();
        test_in_acc();
        test_echo();
        test_handshake();
        test_abort();
        test_nop();
        test_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_transfer_sequencer.md
Name: dp_transfer_sequencer

Overview:
- Controller that sequences the 8-bit datapath's register transfers by driving its seldst/selsrc/dsten/srcen controls.
- Accepts a 3-bit macro command via a start/busy/done handshake and expands it into one or two timed micro-transfers (select setup, then destination-enable hold).
- Sits between the MARIE control unit (or a test host) and the datapath; the datapath's clk/rst are shared.

Parameters:
- SETUP_CYCLES, 1, cycles selects+srcen are driven before dsten rises (legal range >=1)
- HOLD_CYCLES, 2, cycles dsten is held high per transfer (legal range >=1)
- CNT_W, 8, width of the internal phase counter; must hold max(SETUP_CYCLES,HOLD_CYCLES)-1

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  command request, sampled only in IDLE
- cmd  input  3  macro command, latched when start is accepted
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse at command completion
- seldst  output  3  datapath destination select (1=ACC, 2=BREG, 4=PortOUT, 0=none)
- selsrc  output  3  datapath source select (1=ACC, 2=BREG, 3=PortIN, 0=none)
- srcen  output  1  datapath source enable
- dsten  output  1  datapath destination enable

Behaviour:
- All outputs registered (Moore on state). Reset: state=IDLE, busy=0, done=0, seldst=0, selsrc=0, srcen=0, dsten=0, counter=0, latched cmd=0.
- Reset has priority over all other inputs, including start, at the same edge.
- Commands (transfer = src->dst):
  - 0 NOP (none)
  - 1 IN_ACC (3->1)
  - 2 IN_BREG (3->2)
  - 3 OUT_ACC (1->4)
  - 4 OUT_BREG (2->4)
  - 5 MOV_AB (1->2)
  - 6 MOV_BA (2->1)
  - 7 ECHO (3->1, then 1->4)
- States: IDLE, SETUP, XFER, DONE.
- IDLE:
  - Outputs 0.
  - On start=1: latch cmd, step=0, and go to DONE if cmd=0, else to SETUP.
- SETUP:
  - seldst/selsrc = current step's codes, srcen=1, dsten=0, busy=1.
  - Lasts exactly SETUP_CYCLES cycles (counter loaded with SETUP_CYCLES-1, decremented, exit at 0), then go to XFER.
- XFER:
  - Same selects, srcen=1, dsten=1.
  - Lasts exactly HOLD_CYCLES cycles.
  - On exit: if cmd=7 and step=0, set step=1 and go to SETUP; otherwise go to DONE.
- DONE:
  - selects=0, srcen=0, dsten=0, busy=1, done=1 for exactly one cycle, then go to IDLE.
- Latency from the accepting edge to the done cycle: S+H+1 cycles for a single transfer, 2(S+H)+1 for ECHO, 1 for NOP. busy deasserts the cycle after done.
- Selects never change while dsten=1. dsten is never high in the same cycle as a select change.
- start or cmd changes while busy are ignored. cmd is not re-sampled.
- start held high through DONE: the next command is accepted at the IDLE cycle edge. Minimum gap between commands is one IDLE cycle.
- rst mid-command (any state): the next edge forces IDLE with all outputs 0, and no done pulse is produced. The aborted transfer is not resumed.

Test Plan:
- Reset: rst=1 with start=1, cmd=1 for 3 cycles -> all outputs 0 and busy=0 throughout; after rst=0, outputs stay 0 until start.
- IN_ACC (S=1, H=2): start accepted at edge 0 ->
  - cycle 1: seldst=1, selsrc=3, srcen=1, dsten=0
  - cycles 2-3: dsten=1
  - cycle 4: done=1 with selects 0
  - cycle 5: busy=0
- ECHO (S=1, H=2):
  - cycles 1-3: transfer 3->1
  - cycles 4-6: seldst=4, selsrc=1 (dsten=1 in cycles 5-6)
  - cycle 7: done=1
  - dsten=0 at cycle 4
- Handshake: during an OUT_BREG command, toggle start with cmd=5 -> ignored and OUT_BREG completes unchanged. With start held high after done, MOV_AB is accepted at the following IDLE edge and seldst=2, selsrc=1 appear one cycle later.
- Abort: assert rst for one cycle during XFER of IN_BREG -> next cycle all outputs 0 and no done pulse; a subsequent OUT_ACC completes normally with done at S+H+1.
- NOP and parameter sweep: cmd=0 -> done=1 in cycle 1, srcen/dsten never high. With S=3, H=4 and IN_ACC -> srcen-only for 3 cycles, dsten for 4, done at cycle 8.
